// File: rtl/pipeline_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_dmem_responder
// Purpose  : Data-memory responder for the MEM stage. Accepts one load/store
//            at a time, waits a programmable latency, then returns read data
//            or a write acknowledge over a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_dmem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [15:0]       txn_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] C_LAT_M1 = 4'(LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [15:0]       txn_q;

  logic              w_accept;
  logic              w_commit;
  logic              w_handshake;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_accept    = (state_q == S_IDLE) && req_valid;
  assign w_handshake = (state_q == S_RESP) && resp_ready;
  // The access happens on the edge that enters RESP; with LAT=1 that is the
  // same edge as acceptance, so the request fields come straight from the port.
  assign w_commit    = (state_d == S_RESP) && (state_q != S_RESP);

  assign w_we       = (state_q == S_IDLE) ? req_we    : we_q;
  assign w_addr     = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign w_wdata    = (state_q == S_IDLE) ? req_wdata : wdata_q;
  // Range check uses the full address; only then are the low bits used as index.
  assign w_in_range = (32'(w_addr) < 32'(DEPTH));
  assign w_idx      = w_addr[IDX_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (LAT == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE:  req_ready  = 1'b1;
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (w_accept) begin
      cnt_q   <= C_LAT_M1;
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Response registers: loaded on commit, cleared on the response handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (w_commit) begin
      err_q   <= ~w_in_range;
      rdata_q <= (!w_we && w_in_range) ? mem_q[w_idx] : '0;
    end else if (w_handshake) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // Completed-transaction counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      txn_q <= '0;
    end else if (w_handshake) begin
      txn_q <= txn_q + 16'd1;
    end
  end

  // Data array: cleared on reset, written only by in-range stores at commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_commit && w_we && w_in_range) begin
      mem_q[w_idx] <= w_wdata;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign txn_count  = txn_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_dmem_responder
// Purpose  : Self-checking bench for pipeline_dmem_responder: directed vector
//            table, random traffic against a reference model, reset abort and
//            LAT=1 back-to-back throughput.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_dmem_responder;

  localparam int LAT_A = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // Instance A: LAT=2
  logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
  logic [7:0]  a_req_addr = '0;
  logic [31:0] a_req_wdata = '0;
  logic        a_resp_valid, a_resp_ready = 1'b0, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic [15:0] a_txn;

  // Instance B: LAT=1
  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
  logic [7:0]  b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_resp_valid, b_resp_ready = 1'b1, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [15:0] b_txn;

  always #5 clk = ~clk;

  pipeline_dmem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .LAT(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .txn_count(a_txn)
  );

  pipeline_dmem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .LAT(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .txn_count(b_txn)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word array and completed-transaction count
  logic [31:0] model_mem [DEPTH];
  int          model_txn = 0;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_txn = 0;
  endtask

  // Expected response from the model, computed from the access rules
  task automatic model_expect(input bit we, input logic [7:0] addr,
                              output logic [31:0] rd, output bit er);
    er = (int'(addr) >= DEPTH);
    rd = (!we && !er) ? model_mem[int'(addr)] : 32'h0;
  endtask

  // One full transaction on instance A with optional response backpressure
  task automatic do_txn(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                        input int stall, input logic [31:0] exp_rd, input bit exp_er);
    int cyc;
    bit ok;
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    a_resp_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      a_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Post-acceptance garbage on the request bus must be ignored
    a_req_valid = 1'b0; a_req_we = ~we;
    a_req_addr = 8'($urandom); a_req_wdata = $urandom;
    if (we && int'(addr) < DEPTH) model_mem[int'(addr)] = wdata;
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (a_resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", cyc, LAT_A);
    chk("resp_rdata", a_resp_rdata, exp_rd);
    chk("resp_err", {31'd0, a_resp_err}, {31'd0, exp_er});
    chk("req_ready_busy", {31'd0, a_req_ready}, 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, a_resp_valid}, 32'd1);
      chk("hold_rdata", a_resp_rdata, exp_rd);
      chk("hold_ready", {31'd0, a_req_ready}, 32'd0);
      chk("hold_txn", {16'd0, a_txn}, model_txn);
    end
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    model_txn = (model_txn + 1) & 32'hFFFF;
    @(negedge clk);
    chk("post_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("post_rdata", a_resp_rdata, 32'd0);
    chk("post_err", {31'd0, a_resp_err}, 32'd0);
    chk("txn_count", {16'd0, a_txn}, model_txn);
  endtask

  initial begin
    logic [31:0] erd;
    bit          eer;
    logic [7:0]  raddr;
    bit          rwe;
    int          acc [4];
    int          nacc;
    int          cyc;

    vecs[0] = '{0, 8'h05, 32'h0,        0, 32'h0,        0};
    vecs[1] = '{1, 8'h0A, 32'hDEADBEEF, 0, 32'h0,        0};
    vecs[2] = '{0, 8'h0A, 32'h0,        0, 32'hDEADBEEF, 0};
    vecs[3] = '{0, 8'h0A, 32'h0,        5, 32'hDEADBEEF, 0};
    vecs[4] = '{1, 8'h40, 32'h12345678, 0, 32'h0,        1};
    vecs[5] = '{0, 8'h00, 32'h0,        0, 32'h0,        0};
    vecs[6] = '{1, 8'h3F, 32'hCAFEF00D, 1, 32'h0,        0};
    vecs[7] = '{0, 8'h3F, 32'h0,        2, 32'hCAFEF00D, 0};
    vecs[8] = '{0, 8'hFF, 32'h0,        0, 32'h0,        1};

    // Reset for two cycles, then check idle outputs
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("rst_rdata", a_resp_rdata, 32'd0);
    chk("rst_err", {31'd0, a_resp_err}, 32'd0);
    chk("rst_txn", {16'd0, a_txn}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255))
                                          : 8'($urandom_range(0, 7));
      model_expect(rwe, raddr, erd, eer);
      do_txn(rwe, raddr, $urandom, $urandom_range(0, 3), erd, eer);
    end

    // Reset during WAIT aborts the pending store
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'h03; a_req_wdata = 32'hAA;
    @(negedge clk);
    chk("abort_ready", {31'd0, a_req_ready}, 32'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", {31'd0, a_req_ready}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < LAT_A + 3; k++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, a_resp_valid}, 32'd0);
    end
    chk("abort_txn", {16'd0, a_txn}, 32'd0);
    do_txn(1'b0, 8'h03, 32'h0, 0, 32'h0, 1'b0);

    // LAT=1 back-to-back loads, resp_ready tied high
    b_resp_ready = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'h00;
    nacc = 0; cyc = 0;
    for (int i = 0; i < 40 && nacc < 4; i++) begin
      @(negedge clk);
      if (b_req_ready) begin
        acc[nacc] = cyc;
        nacc++;
        @(posedge clk); #1;
        b_req_addr = 8'(nacc);
        if (nacc == 4) b_req_valid = 1'b0;
      end
      cyc++;
    end
    chk("b2b_accepts", nacc, 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < nacc) chk("b2b_spacing", acc[i+1] - acc[i], 32'd2);
    end
    repeat (3) @(negedge clk);
    chk("b2b_txn", {16'd0, b_txn}, 32'd4);
    chk("b2b_idle_valid", {31'd0, b_resp_valid}, 32'd0);
    chk("b2b_err", {31'd0, b_resp_err}, 32'd0);
    chk("b2b_rdata", b_resp_rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pipeline_dmem_responder.md
Name: pipeline_dmem_responder

Overview:
- Responder end of the data-memory request interface driven by the MEM stage of `pipeline_processor`.
- Accepts one load/store request at a time over a valid/ready handshake.
- Models a programmable access latency and returns read data, or a write acknowledge, over a valid/ready response channel.
- Holds the data array internally and counts completed transactions for bench visibility.

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 8, word-address width
- DEPTH, 64, number of implemented words (must be ≤ 2^ADDR_W); addresses ≥ DEPTH are out of range
- LAT, 2, cycles from request acceptance to resp_valid (legal range 1..15)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester consumes the response
- resp_rdata  out  DATA_W  load data (0 for stores and errors)
- resp_err  out  1  request address was out of range
- txn_count  out  16  completed transactions (response handshakes), wraps 0xFFFF→0

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - req_ready=1 from the first cycle after reset deasserts.
  - resp_valid=0, resp_rdata=0, resp_err=0, txn_count=0.
  - All DEPTH memory words are cleared to 0.
  - Reset asserted mid-transaction aborts it: no pending write commits and no response is produced.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid is high at an edge, the responder captures we/addr/wdata and loads the latency counter with LAT-1.
    - LAT=1: go to RESP.
    - LAT>1: go to WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle; at the edge where the counter equals 1, go to RESP.
    - Net timing: a request accepted at edge N has resp_valid high from edge N+LAT.
  - RESP: resp_valid=1, req_ready=0.
    - resp_rdata, resp_err and resp_valid are held stable until resp_ready=1 at an edge.
    - On that edge: go to IDLE, increment txn_count, clear resp_valid/resp_rdata/resp_err.
- Memory access commits on the edge entering RESP, using the captured fields (not the live inputs):
  - Load: resp_rdata = mem[addr].
  - Store: mem[addr] = wdata, resp_rdata = 0.
  - addr ≥ DEPTH: no write occurs, resp_rdata = 0, resp_err = 1.
- Throughput:
  - At most one request outstanding.
  - No same-cycle response-to-request turnaround: the minimum spacing between acceptances is LAT+1 cycles with resp_ready tied high.
- Input handling:
  - req_valid while req_ready=0 is ignored; the requester must hold the request until it is accepted.
  - Changes to req_* after acceptance have no effect.
  - resp_ready while resp_valid=0 is ignored.
- A store followed by a load to the same address returns the stored value; there is no forwarding hazard because requests serialise.
- Width rules:
  - Memory is indexed with the low bits of the captured address only after the range check passes.
  - txn_count is a 16-bit unsigned wrapping counter.

Test Plan:
- Reset: assert reset for 2 cycles → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, txn_count=0; a load of addr 5 returns 0.
- Store then load, LAT=2:
  - Store addr 0x0A, data 0xDEADBEEF, accepted at edge N → resp_valid at N+2 with rdata=0, err=0; txn_count=1.
  - Load addr 0x0A → rdata=0xDEADBEEF, txn_count=2.
- Backpressure: load addr 0x0A with resp_ready=0 for 5 cycles → resp_valid, rdata and req_ready=0 held stable for all 5 cycles; resp_ready=1 → single handshake, txn_count increments by exactly 1, req_ready=1 on the next cycle.
- Out of range: store addr 0x40 (DEPTH=64), data 0x12345678 → resp_err=1, rdata=0; a subsequent load of addr 0x00 returns 0 (no aliasing write).
- Reset mid-operation: accept store addr 3, data 0xAA, then assert reset during WAIT → no response appears; a load of addr 3 after reset returns 0, and txn_count=0.
- Back-to-back with resp_ready tied high, LAT=1: 4 loads held on req_valid → acceptances exactly 2 cycles apart; txn_count=4. Covering txn_count wrap by preloading 0xFFFF via 65535 transactions is optional long-run coverage: the next completion must give 0.
